// File: rtl/code_packer.sv
// Stage-1 output packer: concatenates right-aligned variable-length codes MSB-first
// into fixed-width words, with a flush that closes the frame on a zero-padded last beat.
module code_packer #(
  parameter int OUT_W  = 64,
  parameter int CODE_W = 34,
  parameter int LEN_W  = 6,
  parameter int BUF_W  = 128
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [CODE_W-1:0] i_code,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_flush,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [OUT_W-1:0]  o_data,
  output logic              o_last,
  output logic [6:0]        o_nbits,
  output logic              o_busy
);

  localparam int FILL_W = $clog2(BUF_W + 1);
  localparam logic [FILL_W-1:0] OUT_W_F  = FILL_W'(OUT_W);
  localparam logic [FILL_W-1:0] BUF_W_F  = FILL_W'(BUF_W);
  localparam logic [LEN_W-1:0]  CODE_W_L = LEN_W'(CODE_W);

  typedef enum logic {PACK, DRAIN} state_t;

  state_t              state_q, state_d;
  logic [BUF_W-1:0]    acc_q, acc_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [CODE_W-1:0]   code_mask;
  logic [BUF_W-1:0]    code_ext;
  logic [FILL_W-1:0]   ins_shamt;
  logic                accept, flush_take, emit;
  logic                ready_d, valid_d, last_d, busy_d;
  logic [6:0]          nbits_d;

  // The accumulator keeps every bit below fill at zero, so the padded last beat
  // needs no extra masking on the way out.
  assign o_data = acc_q[BUF_W-1 -: OUT_W];

  assign accept     = i_valid & o_ready;
  assign flush_take = i_flush & o_ready;
  assign emit       = o_valid & i_ready;

  assign code_mask = {CODE_W{1'b1}} >> (CODE_W_L - i_len);
  assign code_ext  = BUF_W'(i_code & code_mask);
  assign ins_shamt = BUF_W_F - fill_q - FILL_W'(i_len);

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    acc_d   = acc_q;
    fill_d  = fill_q;
    state_d = state_q;

    // Accept and emit never coincide: o_ready and o_valid are disjoint by construction.
    if (accept) begin
      acc_d  = acc_q | (code_ext << ins_shamt);
      fill_d = fill_q + FILL_W'(i_len);
    end
    if (flush_take) begin
      state_d = DRAIN;
    end

    if (emit) begin
      if (state_q == DRAIN && fill_q <= OUT_W_F) begin
        acc_d   = '0;
        fill_d  = '0;
        state_d = PACK;
      end else begin
        acc_d  = acc_q << OUT_W;
        fill_d = fill_q - OUT_W_F;
      end
    end

    // Outputs are decoded from next state so they can be registered.
    ready_d = (state_d == PACK) && (fill_d < OUT_W_F);
    valid_d = (state_d == DRAIN) || (fill_d >= OUT_W_F);
    last_d  = (state_d == DRAIN) && (fill_d <= OUT_W_F);
    nbits_d = last_d ? 7'(fill_d) : 7'(OUT_W);
    busy_d  = (state_d == DRAIN) || (fill_d != '0);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= PACK;
      acc_q   <= '0;
      fill_q  <= '0;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_nbits <= '0;
      o_busy  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      o_ready <= ready_d;
      o_valid <= valid_d;
      o_last  <= last_d;
      o_nbits <= nbits_d;
      o_busy  <= busy_d;
    end
  end

endmodule

// File: tb/tb_code_packer.sv
// Self-checking bench for code_packer: a bit-level reference queue is filled as codes
// are accepted and drained as output beats complete, plus directed frame checks.
module tb_code_packer;

  localparam int OUT_W  = 64;
  localparam int CODE_W = 34;
  localparam int LEN_W  = 6;
  localparam int BUF_W  = 128;

  logic              i_clk = 1'b0;
  logic              i_reset = 1'b1;
  logic              i_valid = 1'b0;
  logic [CODE_W-1:0] i_code = '0;
  logic [LEN_W-1:0]  i_len = '0;
  logic              i_flush = 1'b0;
  logic              i_ready = 1'b1;
  logic              o_ready, o_valid, o_last, o_busy;
  logic [OUT_W-1:0]  o_data;
  logic [6:0]        o_nbits;

  code_packer #(.OUT_W(OUT_W), .CODE_W(CODE_W), .LEN_W(LEN_W), .BUF_W(BUF_W)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_code(i_code), .i_len(i_len), .i_flush(i_flush), .o_valid(o_valid),
    .i_ready(i_ready), .o_data(o_data), .o_last(o_last), .o_nbits(o_nbits),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference state: pending bits of the current frame, and whether its flush was taken.
  bit          ref_bits[$];
  bit          flush_pend = 1'b0;
  int          beats = 0;
  logic [63:0] data_log[$];
  logic [6:0]  nbits_log[$];
  logic        last_log[$];
  longint      total_out = 0;
  int          ready_mode = 0;  // 0: always ready, 1: held low, 2: random

  logic [63:0] exp_data;
  int          exp_take;
  bit          exp_last;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge i_clk) begin
    #1;
    case (ready_mode)
      0:       i_ready = 1'b1;
      1:       i_ready = 1'b0;
      default: i_ready = ($urandom_range(0, 3) != 0);
    endcase
  end

  always @(negedge i_clk) begin
    if (i_valid) assert (i_len <= LEN_W'(CODE_W)) else $error("illegal i_len %0d", i_len);
  end

  // Monitor: checks handshake flags against the reference, then records this cycle's events.
  always @(negedge i_clk) begin
    if (!i_reset) begin
      check("ready", 64'(o_ready), 64'(!flush_pend && ref_bits.size() < 64));
      check("valid", 64'(o_valid), 64'(flush_pend || ref_bits.size() >= 64));
      check("busy",  64'(o_busy),  64'(flush_pend || ref_bits.size() != 0));
      if (i_valid && o_ready) begin
        for (int b = int'(i_len) - 1; b >= 0; b--) ref_bits.push_back(i_code[b]);
      end
      if (o_ready && i_flush) flush_pend = 1'b1;
      if (o_valid && i_ready) begin
        exp_last = flush_pend && (ref_bits.size() <= 64);
        exp_take = exp_last ? ref_bits.size() : 64;
        exp_data = '0;
        for (int k = 0; k < exp_take; k++) begin
          if (ref_bits.size() > 0) exp_data[63-k] = ref_bits.pop_front();
        end
        check("data",  o_data, exp_data);
        check("last",  64'(o_last), 64'(exp_last));
        check("nbits", 64'(o_nbits), 64'(exp_take));
        if (exp_last) flush_pend = 1'b0;
        beats++;
        data_log.push_back(o_data);
        nbits_log.push_back(o_nbits);
        last_log.push_back(o_last);
        total_out += longint'(o_nbits);
      end
    end
  end

  // Presents one code (or a lone flush when valid=0) and holds it until accepted.
  task automatic send(input logic [CODE_W-1:0] code, input int len, input bit flush,
                      input bit valid);
    int n;
    i_valid = valid;
    i_code  = code;
    i_len   = LEN_W'(len);
    i_flush = flush;
    for (n = 0; n < 500; n++) begin
      @(negedge i_clk);
      if (o_ready) break;
    end
    if (n == 500) check("accept_timeout", 64'(o_ready), 64'd1);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_flush = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    for (n = 0; n < 5000; n++) begin
      @(negedge i_clk);
      if (!o_busy) break;
    end
    if (n == 5000) check("idle_timeout", 64'(o_busy), 64'd0);
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    logic [63:0] held;
    longint sum_len;
    int len;
    int r;

    // Reset state
    #2;
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_last",  64'(o_last),  64'd0);
    check("rst_data",  o_data,       64'd0);
    check("rst_nbits", 64'(o_nbits), 64'd0);
    check("rst_busy",  64'(o_busy),  64'd0);
    repeat (2) @(posedge i_clk);
    #2;
    i_reset = 1'b0;
    #1;
    check("rst_ready", 64'(o_ready), 64'd1);
    @(posedge i_clk);
    #1;

    // Test 1: six 12-bit codes then a lone flush
    b0 = beats;
    repeat (6) send(34'hD5A, 12, 1'b0, 1'b1);
    send('0, 0, 1'b1, 1'b0);
    wait_idle();
    check("t1_beats", 64'(beats - b0), 64'd2);
    if (beats - b0 == 2) begin
      check("t1_b1_data",  data_log[b0],            64'hD5AD5AD5AD5AD5AD);
      check("t1_b1_last",  64'(last_log[b0]),       64'd0);
      check("t1_b1_nbits", 64'(nbits_log[b0]),      64'd64);
      check("t1_b2_data",  data_log[b0+1],          64'h5A00_0000_0000_0000);
      check("t1_b2_last",  64'(last_log[b0+1]),     64'd1);
      check("t1_b2_nbits", 64'(nbits_log[b0+1]),    64'd8);
    end

    // Test 2: flush on an empty buffer
    b0 = beats;
    send('0, 0, 1'b1, 1'b0);
    wait_idle();
    check("t2_beats", 64'(beats - b0), 64'd1);
    if (beats - b0 == 1) begin
      check("t2_data",  data_log[b0],         64'd0);
      check("t2_last",  64'(last_log[b0]),    64'd1);
      check("t2_nbits", 64'(nbits_log[b0]),   64'd0);
    end
    check("t2_busy", 64'(o_busy), 64'd0);

    // Test 3: exactly 64 bits with flush on the second code, no trailing empty beat
    b0 = beats;
    send(34'hFFFF0000, 32, 1'b0, 1'b1);
    send(34'h12345678, 32, 1'b1, 1'b1);
    wait_idle();
    check("t3_beats", 64'(beats - b0), 64'd1);
    if (beats - b0 == 1) begin
      check("t3_data",  data_log[b0],        64'hFFFF0000_12345678);
      check("t3_last",  64'(last_log[b0]),   64'd1);
      check("t3_nbits", 64'(nbits_log[b0]),  64'd64);
    end

    // Test 4: 72 bits buffered with the output held off for five cycles
    ready_mode = 1;
    @(posedge i_clk);
    #1;
    b0 = beats;
    send(34'hA5A5A5A5, 32, 1'b0, 1'b1);
    send(34'h12345678, 30, 1'b0, 1'b1);
    send(34'h2C3, 10, 1'b0, 1'b1);
    held = o_data;
    repeat (5) begin
      @(negedge i_clk);
      check("t4_hold_data",  o_data,        held);
      check("t4_hold_valid", 64'(o_valid),  64'd1);
      check("t4_hold_ready", 64'(o_ready),  64'd0);
    end
    ready_mode = 0;
    send('0, 0, 1'b1, 1'b0);
    wait_idle();
    check("t4_beats", 64'(beats - b0), 64'd2);
    if (beats - b0 == 2) begin
      check("t4_b1_data",  data_log[b0],          {32'hA5A5A5A5, 30'h12345678, 2'b10});
      check("t4_b2_data",  data_log[b0+1],        64'hC300_0000_0000_0000);
      check("t4_b2_nbits", 64'(nbits_log[b0+1]),  64'd8);
    end

    // Test 5: 1000 random codes with random back-pressure, then flush
    ready_mode = 2;
    total_out = 0;
    sum_len = 0;
    for (int i = 0; i < 1000; i++) begin
      r = $urandom_range(0, 19);
      len = (r == 0) ? 0 : (r < 8) ? 2 : (r < 14) ? 12 : 34;
      sum_len += longint'(len);
      send(CODE_W'({$urandom, $urandom}), len, 1'b0, 1'b1);
    end
    send('0, 0, 1'b1, 1'b0);
    wait_idle();
    ready_mode = 0;
    check("t5_total_bits", 64'(total_out), 64'(sum_len));
    check("t5_final_last", 64'(last_log[$]), 64'd1);

    // Test 6: reset while draining with a beat pending
    ready_mode = 1;
    @(posedge i_clk);
    #1;
    send(34'h155, 10, 1'b1, 1'b1);
    @(posedge i_clk);
    #2;
    check("t6_pre_valid", 64'(o_valid), 64'd1);
    i_reset = 1'b1;
    ref_bits.delete();
    flush_pend = 1'b0;
    #1;
    check("t6_rst_valid", 64'(o_valid), 64'd0);
    check("t6_rst_last",  64'(o_last),  64'd0);
    check("t6_rst_busy",  64'(o_busy),  64'd0);
    @(posedge i_clk);
    #2;
    i_reset = 1'b0;
    ready_mode = 0;
    #1;
    check("t6_ready", 64'(o_ready), 64'd1);
    b0 = beats;
    send('0, 2, 1'b1, 1'b1);
    wait_idle();
    check("t6_beats", 64'(beats - b0), 64'd1);
    if (beats - b0 == 1) begin
      check("t6_data",  data_log[b0],        64'd0);
      check("t6_nbits", 64'(nbits_log[b0]),  64'd2);
      check("t6_last",  64'(last_log[b0]),   64'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/code_packer.md
Name: code_packer

Overview:
- Stage-1 output packer of the compressor.
- Takes one right-aligned variable-length code per handshake from the comparator/encoder stage. Each code is 1..34 bits: 2-bit zzzz, 12-bit zzzx, up to 34-bit uncompressed.
- Concatenates codes MSB-first into fixed 64-bit words for the stage-2 output buffer.
- A flush request closes the frame and emits the zero-padded partial word tagged last.

Parameters:
- OUT_W, 64: output word width.
- CODE_W, 34: maximum code width. Must satisfy CODE_W <= OUT_W.
- LEN_W, 6: width of the code-length field.
- BUF_W, 128: accumulator width. Must satisfy BUF_W >= OUT_W + CODE_W - 1.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_valid  in  1  code present.
- o_ready  out  1  packer accepts the code this cycle.
- i_code  in  CODE_W  code, right-aligned in bits [i_len-1:0]. Upper bits are don't-care.
- i_len  in  LEN_W  code length, 0..CODE_W.
- i_flush  in  1  end of frame. Qualified by i_valid & o_ready, or sampled alone when i_valid=0 and o_ready=1.
- o_valid  out  1  output word present.
- i_ready  in  1  downstream accepts the word.
- o_data  out  OUT_W  packed word; the first code occupies the MSBs.
- o_last  out  1  final word of the frame.
- o_nbits  out  7  number of meaningful MSBs in o_data, 0..64.
- o_busy  out  1  high when the buffer is non-empty or the block is in DRAIN.

Behaviour:
- Reset (asynchronous, immediate): o_valid=0, o_last=0, o_data=0, o_nbits=0, o_busy=0, fill=0, state=PACK. o_ready reads 1 after reset release.
- Registers:
  - buf[BUF_W-1:0], the valid bits, left-justified.
  - fill, the valid-bit count, 0..BUF_W.
  - state, one of PACK or DRAIN.
- o_data = buf[BUF_W-1 -: OUT_W], driven directly from registers. It is stable while o_valid=1 and i_ready=0.
- PACK state:
  - o_ready = (fill < OUT_W).
  - o_valid = (fill >= OUT_W); o_last=0; o_nbits=64.
  - Accept (i_valid & o_ready): buf[BUF_W-1-fill -: i_len] <= i_code[i_len-1:0], and fill += i_len.
  - i_len=0 is a legal no-op: accepted, no change to buf or fill.
  - i_len > CODE_W is illegal. The bench asserts on it; RTL behaviour is unspecified.
  - Emit (o_valid & i_ready): buf <<= OUT_W, zero-filled; fill -= OUT_W.
  - Accept and emit are mutually exclusive in PACK, because o_ready and o_valid are disjoint.
  - i_flush qualified (with or without an accompanying code) -> the code, if any, is appended, then next state = DRAIN.
- DRAIN state:
  - o_ready=0; input is stalled.
  - o_valid=1 always.
  - If fill > OUT_W: o_last=0, o_nbits=64. On emit, shift the buffer and stay in DRAIN.
  - If fill <= OUT_W: o_last=1, o_nbits=fill, and the unused LSBs are 0.
    - fill=0 produces a single all-zero beat with o_nbits=0, so the frame end is always signalled.
    - On emit: fill=0, buf=0, next state = PACK.
- Latency: a code accepted in cycle t that completes a word gives o_valid=1 in cycle t+1.
- Throughput: one code per cycle until fill >= 64, then one stall cycle per emitted word when i_ready=1.
- Back-pressure: while o_valid=1 and i_ready=0, o_data, o_last, o_nbits, buf and fill all hold.
- Reset mid-operation, in either state, discards buffered bits and any pending flush. No last beat is emitted.

Test Plan:
1. Six codes, each i_code=12'hD5A with i_len=12, then i_flush alone.
   - Beat 1: o_data=64'hD5AD5AD5AD5AD5AD, o_last=0, o_nbits=64.
   - Beat 2: o_data=64'h5A00_0000_0000_0000, o_last=1, o_nbits=8.
   - o_ready is 0 exactly while fill>=64.
2. i_flush with an empty buffer -> one beat: o_data=0, o_last=1, o_nbits=0. o_busy falls the cycle after the handshake.
3. Codes 32'hFFFF0000 (len 32), then 32'h12345678 (len 32) presented together with i_flush.
   - Exactly one beat: o_data=64'hFFFF0000_12345678, o_last=1, o_nbits=64.
   - No trailing zero beat.
4. Fill to 72 bits, then hold i_ready=0 for 5 cycles.
   - o_data, o_valid=1 and o_ready=0 are constant throughout.
   - After release, the remaining 8 bits appear correctly.
   - Scoreboard shows no lost or duplicated bits.
5. Mixed stream of 2/12/34-bit codes, 1000 random codes with random i_ready, then flush.
   - Concatenated output bits, truncated to the final o_nbits, equal the reference bitstream.
   - Total bits equal the sum of all i_len.
6. Assert i_reset while in DRAIN with o_valid=1.
   - o_valid, o_last and o_busy go to 0 immediately (asynchronously).
   - After release, o_ready=1, and a fresh code 2'b00 (len 2) plus flush gives o_data=0, o_nbits=2, o_last=1.
